// File: rtl/cook_timer.sv
// cook_timer: BCD MM:SS countdown stage fed by the microwave controller.
// Captures a sanitised load value, counts it down once per CLK_DIV clocks
// while cook is high, and returns a one-cycle done pulse at expiry.
// Optional feature macro: COOK_TIMER_BLINK_EN (blink 0000/FFFF while expired).
module cook_timer #(
  parameter int CLK_DIV = 50000000,
  parameter int PW      = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] time_load,
  input  logic        load,
  input  logic        cook,
  output logic [15:0] time_out,
  output logic        done,
  output logic        running
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [15:0]   r_count;
  logic [15:0]   w_nextCount;
  logic [15:0]   w_decCount;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_nextPresc;
  logic          r_done;
  logic          w_nextDone;
  logic          w_wrap;
  logic          w_advance;
`ifdef COOK_TIMER_BLINK_EN
  logic          r_blank;
  logic          w_nextBlank;
`endif

  // Clamp out-of-range digits: any digit above 9 becomes 9, tens-of-seconds above 5 becomes 5.
  function automatic logic [15:0] sanitise(input logic [15:0] v);
    logic [3:0] tm, m, ts, s;
    tm = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
    m  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
    ts = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
    s  = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
    return {tm, m, ts, s};
  endfunction

  // Subtract one second from an MM:SS BCD value with a digit borrow chain, saturating at 0000.
  function automatic logic [15:0] bcdDec(input logic [15:0] v);
    logic [3:0] tm, m, ts, s;
    logic       b;
    {tm, m, ts, s} = v;
    b = 1'b0;
    if (v != 16'h0000) begin
      if (s == 4'd0) begin
        s = 4'd9;
        b = 1'b1;
      end else begin
        s = s - 4'd1;
      end
      if (b) begin
        if (ts == 4'd0) begin
          ts = 4'd5;
        end else begin
          ts = ts - 4'd1;
          b  = 1'b0;
        end
      end
      if (b) begin
        if (m == 4'd0) begin
          m = 4'd9;
        end else begin
          m = m - 4'd1;
          b = 1'b0;
        end
      end
      if (b) begin
        tm = tm - 4'd1;
      end
    end
    return {tm, m, ts, s};
  endfunction

  assign w_wrap     = (r_presc == PRESC_MAX);
  assign w_decCount = bcdDec(r_count);

  // State register; everything returns to idle/zero the moment reset goes low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: load wins outright, otherwise IDLE/RUN advance the prescaler while cooking.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextPresc = r_presc;
    w_nextDone  = 1'b0;
    w_advance   = 1'b0;
`ifdef COOK_TIMER_BLINK_EN
    w_nextBlank = 1'b0;
`endif
    if (load) begin
      w_nextState = IDLE;
      w_nextCount = sanitise(time_load);
      w_nextPresc = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cook) begin
            if (r_count == 16'h0000) begin
              w_nextState = EXPIRED;
              w_nextDone  = 1'b1;
`ifdef COOK_TIMER_BLINK_EN
              w_nextPresc = '0;
`endif
            end else begin
              w_advance = 1'b1;
            end
          end
        end
        RUN: begin
          if (cook) begin
            w_advance = 1'b1;
          end else begin
            w_nextState = IDLE;
          end
        end
        EXPIRED: begin
          if (!cook) begin
            w_nextState = IDLE;
          end else begin
`ifdef COOK_TIMER_BLINK_EN
            w_nextBlank = w_wrap ? ~r_blank : r_blank;
            w_nextPresc = w_wrap ? '0 : r_presc + PW'(1);
`endif
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
      if (w_advance) begin
        w_nextState = RUN;
        if (w_wrap) begin
          w_nextPresc = '0;
          w_nextCount = w_decCount;
          if (w_decCount == 16'h0000) begin
            w_nextState = EXPIRED;
            w_nextDone  = 1'b1;
          end
        end else begin
          w_nextPresc = r_presc + PW'(1);
        end
      end
    end
  end

  // Datapath registers: count, prescaler, done pulse and blink phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 16'h0000;
      r_presc <= '0;
      r_done  <= 1'b0;
`ifdef COOK_TIMER_BLINK_EN
      r_blank <= 1'b0;
`endif
    end else begin
      r_count <= w_nextCount;
      r_presc <= w_nextPresc;
      r_done  <= w_nextDone;
`ifdef COOK_TIMER_BLINK_EN
      r_blank <= w_nextBlank;
`endif
    end
  end

`ifdef COOK_TIMER_BLINK_EN
  assign time_out = r_blank ? 16'hFFFF : r_count;
`else
  assign time_out = r_count;
`endif
  assign done    = r_done;
  assign running = (r_state == RUN);

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer with CLK_DIV=4: a table of directed
// vectors followed by hand-written reset-mid-run and blink sequences.
module tb_cook_timer;

  typedef struct {
    logic        ld;
    logic        ck;
    logic [15:0] tl;
    int          n;
    logic [15:0] expT;
    logic        expD;
    logic        expR;
  } vec_t;

  logic        clk;
  logic        resetN;
  logic [15:0] timeLoad;
  logic        load;
  logic        cook;
  logic [15:0] timeOut;
  logic        done;
  logic        running;

  int checks;
  int failures;
  vec_t vecs[$];

  cook_timer #(.CLK_DIV(4), .PW(3)) dut (
    .clk(clk),
    .reset(resetN),
    .time_load(timeLoad),
    .load(load),
    .cook(cook),
    .time_out(timeOut),
    .done(done),
    .running(running)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input logic ld, input logic ck, input logic [15:0] tl, input int n,
                        input logic [15:0] expT, input logic expD, input logic expR);
    vec_t v;
    v.ld = ld; v.ck = ck; v.tl = tl; v.n = n;
    v.expT = expT; v.expD = expD; v.expR = expR;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expT, input logic expD,
                             input logic expR);
    checks = checks + 3;
    if (timeOut !== expT) begin
      failures = failures + 1;
      $display("[TB] FAIL %s time_out actual=%h required=%h", name, timeOut, expT);
    end
    if (done !== expD) begin
      failures = failures + 1;
      $display("[TB] FAIL %s done actual=%b required=%b", name, done, expD);
    end
    if (running !== expR) begin
      failures = failures + 1;
      $display("[TB] FAIL %s running actual=%b required=%b", name, running, expR);
    end
  endtask

  // Drive inputs at a falling edge, let n rising edges pass, land on a falling edge.
  task automatic applyStimulus(input logic ld, input logic ck, input logic [15:0] tl, input int n);
    load = ld;
    cook = ck;
    timeLoad = tl;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int doneSeen;
    checks   = 0;
    failures = 0;
    resetN   = 1'b0;
    load     = 1'b0;
    cook     = 1'b0;
    timeLoad = 16'h0000;

    // Basic countdown from 00:10
    addVec(1, 0, 16'h0010, 1,  16'h0010, 0, 0);
    addVec(0, 1, 16'h0000, 3,  16'h0010, 0, 1);
    addVec(0, 1, 16'h0000, 1,  16'h0009, 0, 1);
    addVec(0, 1, 16'h0000, 35, 16'h0001, 0, 1);
    addVec(0, 1, 16'h0000, 1,  16'h0000, 1, 0);
    addVec(0, 1, 16'h0000, 1,  16'h0000, 0, 0);
    // Borrow chains
    addVec(1, 0, 16'h1000, 1,  16'h1000, 0, 0);
    addVec(0, 1, 16'h0000, 4,  16'h0959, 0, 1);
    addVec(1, 0, 16'h0100, 1,  16'h0100, 0, 0);
    addVec(0, 1, 16'h0000, 4,  16'h0059, 0, 1);
    // Sanitising
    addVec(1, 0, 16'h0A7C, 1,  16'h0959, 0, 0);
    addVec(1, 0, 16'hFFFF, 1,  16'h9959, 0, 0);
    // Pause / resume keeps the partial second
    addVec(1, 0, 16'h0005, 1,  16'h0005, 0, 0);
    addVec(0, 1, 16'h0000, 6,  16'h0004, 0, 1);
    addVec(0, 0, 16'h0000, 20, 16'h0004, 0, 0);
    addVec(0, 1, 16'h0000, 1,  16'h0004, 0, 1);
    addVec(0, 1, 16'h0000, 1,  16'h0003, 0, 1);
    // Load colliding with a prescaler wrap
    addVec(0, 1, 16'h0000, 3,  16'h0003, 0, 1);
    addVec(1, 1, 16'h0042, 1,  16'h0042, 0, 0);
    addVec(0, 1, 16'h0000, 1,  16'h0042, 0, 1);
    // Zero start and re-pulse after leaving EXPIRED
    addVec(1, 0, 16'h0000, 1,  16'h0000, 0, 0);
    addVec(0, 1, 16'h0000, 1,  16'h0000, 1, 0);
    addVec(0, 1, 16'h0000, 1,  16'h0000, 0, 0);
    addVec(0, 0, 16'h0000, 1,  16'h0000, 0, 0);
    addVec(0, 1, 16'h0000, 1,  16'h0000, 1, 0);
    addVec(0, 0, 16'h0000, 1,  16'h0000, 0, 0);

    #3;
    checkOutput("reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ld, vecs[i].ck, vecs[i].tl, vecs[i].n);
      checkOutput($sformatf("vec%0d", i), vecs[i].expT, vecs[i].expD, vecs[i].expR);
    end

    // Asynchronous reset in the middle of a run
    applyStimulus(1, 0, 16'h0007, 1);
    applyStimulus(0, 1, 16'h0000, 2);
    checkOutput("preReset", 16'h0007, 1'b0, 1'b1);
    #2 resetN = 1'b0;
    #1 checkOutput("asyncReset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    load = 1'b0;
    cook = 1'b0;
    resetN = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) doneSeen = doneSeen + 1;
    end
    checks = checks + 1;
    if (doneSeen != 0) begin
      failures = failures + 1;
      $display("[TB] FAIL postResetDone pulses actual=%0d required=0", doneSeen);
    end
    checkOutput("postReset", 16'h0000, 1'b0, 1'b0);

`ifdef COOK_TIMER_BLINK_EN
    // Expired display blinks every CLK_DIV cycles, cleared as soon as cook drops
    applyStimulus(1, 0, 16'h0001, 1);
    applyStimulus(0, 1, 16'h0000, 4);
    checkOutput("blinkEntry", 16'h0000, 1'b1, 1'b0);
    applyStimulus(0, 1, 16'h0000, 3);
    checkOutput("blinkHold", 16'h0000, 1'b0, 1'b0);
    applyStimulus(0, 1, 16'h0000, 1);
    checkOutput("blinkOn1", 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, 1, 16'h0000, 4);
    checkOutput("blinkOff", 16'h0000, 1'b0, 1'b0);
    applyStimulus(0, 1, 16'h0000, 4);
    checkOutput("blinkOn2", 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, 0, 16'h0000, 1);
    checkOutput("blinkExit", 16'h0000, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- Countdown stage directly downstream of the microwave controller.
- Captures the 16-bit BCD MM:SS value presented with load, then counts it down one second at a time while cook is high.
- Drives the display value and returns a one-cycle done pulse to the controller's done input at expiry.
- Contains an internal prescaler, so no external 1 Hz tick is needed.

Parameters:
- CLK_DIV, 50000000, clk cycles per one-second decrement (must be >= 2).
- PW, 26, prescaler width; must satisfy 2^PW >= CLK_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- time_load  input  16  BCD value [15:12] tens-min, [11:8] min, [7:4] tens-sec, [3:0] sec.
- load  input  1  level; capture time_load.
- cook  input  1  level; count down while high.
- time_out  output  16  registered current count, BCD, same digit layout as time_load.
- done  output  1  registered one-cycle expiry pulse.
- running  output  1  high while in state RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - time_out=16'h0000, done=0, running=0.
  - prescaler=0, state=IDLE.
- Load:
  - load=1 at an edge writes the sanitised time_load into time_out at that edge; time_out shows it the next cycle.
  - Sanitising: any digit >9 becomes 9; tens-sec >5 becomes 5.
  - Load also clears the prescaler, forces done=0 and sets state=IDLE.
  - Load has priority over cook and over a same-cycle decrement.
- States:
  - IDLE: running=0, prescaler held. Go to RUN when cook=1 and count!=0. Go to EXPIRED when cook=1 and count==0; done pulses on that edge.
  - RUN: running=1, prescaler increments each cycle.
    - When prescaler==CLK_DIV-1: prescaler wraps to 0 and count decrements by one second.
    - If the new count is 0000, go to EXPIRED and assert done for exactly one cycle (done and time_out=0000 appear together).
    - cook=0 goes to IDLE with prescaler and count frozen (pause). Resume continues from the frozen prescaler value, so no partial second is lost.
  - EXPIRED: running=0, count holds 0000, done=0 after the entry pulse. Exit only via load (to IDLE) or cook=0 (to IDLE). A later cook=1 with count 0000 re-pulses done.
- Decrement arithmetic (BCD with borrow chain):
  - sec 0 becomes 9 and borrows from tens-sec.
  - tens-sec 0 becomes 5 and borrows from min.
  - min 0 becomes 9 and borrows from tens-min.
  - Count is never decremented below 0000.
- done:
  - Never high for more than one consecutive cycle.
  - Never asserted in the same cycle as load=1.
- Reset asserted mid-run returns all state to reset values immediately; no done pulse is produced.
- Latency: load to time_out is 1 cycle; a prescaler wrap to decremented time_out is 1 cycle (registered).

Optional Feature:
- Macro: COOK_TIMER_BLINK_EN.
- Defined: in EXPIRED, time_out alternates between 16'h0000 and 16'hFFFF (downstream 7-seg blank code) every CLK_DIV cycles, starting with 0000 on entry. The prescaler keeps running in EXPIRED. Leaving EXPIRED restores 0000 immediately.
- Undefined: time_out holds 16'h0000 in EXPIRED, and the prescaler is idle there.

Test Plan (CLK_DIV=4):
- Basic countdown: load time_load=16'h0010, then cook=1.
  - time_out steps 0010→0009 after 4 cycles.
  - Reaches 0000 after 40 cycles, with done=1 for exactly 1 cycle on that edge; running falls with it.
- Borrow chain: load 16'h1000, cook=1 → after 4 cycles time_out=16'h0959. Load 16'h0100 → after 4 cycles time_out=16'h0059.
- Sanitising: load 16'h0A7C → time_out=16'h0959 the next cycle.
- Pause/resume: load 0005, cook=1 for 6 cycles (time_out=0004, prescaler=2), cook=0 for 20 cycles (time_out and prescaler frozen), cook=1 → 0003 after exactly 2 more cycles.
- Priority and zero start:
  - load=1 together with a prescaler wrap → loaded value wins, no decrement, done=0.
  - cook=1 with count 0000 → done pulse the next edge, state EXPIRED.
- Reset mid-run: reset=0 asynchronously during RUN at 0007 → time_out=0000, done=0 and running=0 before the next edge, and no done pulse afterwards.
- With COOK_TIMER_BLINK_EN: after expiry, time_out toggles 0000/FFFF every 4 cycles; cook=0 returns 0000 the next cycle.
